jpeg_zigzag_rle_encoder: RTL and testbench
==========================================

# jpeg_zigzag_rle_encoder

Downstream stage of the optimized JPEG compression pipeline. It accepts one zigzag-ordered, quantized 8×8 block per channel (Y, Cb, Cr) as flat parallel vectors and captures them in one handshake. It then walks each channel's 64 coefficients in order and emits a serial stream of JPEG run-length symbols (DC, AC run/size/amplitude, ZRL, EOB) for the entropy coder.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one coefficient (signed two's complement integer)
- PIXEL_COUNT, 64, coefficients per channel block
- AMP_WIDTH, 11, width of sym_amp; coefficients and DC differences saturate to ±(2^AMP_WIDTH−1)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- zigzag_y  in  DATA_WIDTH*PIXEL_COUNT  Y coefficients; index k at bits [k*DATA_WIDTH +: DATA_WIDTH], k=0 is DC
- zigzag_cb  in  DATA_WIDTH*PIXEL_COUNT  Cb coefficients, same layout
- zigzag_cr  in  DATA_WIDTH*PIXEL_COUNT  Cr coefficients, same layout
- in_valid  in  1  block vectors valid
- in_ready  out  1  block accepted when in_valid && in_ready
- sym_valid  out  1  symbol valid
- sym_ready  in  1  downstream accepts symbol
- sym_channel  out  2  0=Y, 1=Cb, 2=Cr
- sym_is_dc  out  1  symbol is the DC term
- sym_run  out  4  zero run before the coefficient (AC only)
- sym_size  out  4  JPEG size category, 0..AMP_WIDTH
- sym_amp  out  AMP_WIDTH  amplitude bits, right-aligned, zero above sym_size
- sym_last  out  1  final symbol of the block (last Cr symbol)

## Operation
- FSM states: IDLE, DC, AC, ZRL, DONE.
- IDLE:
  - in_ready=1.
  - On handshake, register all three vectors, set channel=Y, then go to DC.
- DC:
  - Emit the DC symbol for the current channel: value = coef[0] (or the difference, see Configuration), saturated.
  - Then go to AC with k=1, run=0.
- AC, coefficient k, one per advancing cycle:
  - If zero: run++ and no symbol.
  - If non-zero and run≥16: emit ZRL (run=15, size=0, amp=0), run−=16, and stay on k (state ZRL path). Repeat until run<16.
  - If non-zero and run<16: emit (run, size, amp), then set run=0.
- After k=63:
  - If the last coefficient was zero, emit EOB (run=0, size=0, amp=0).
  - If it was non-zero, emit no EOB.
  - Pending zero runs are discarded; ZRLs are emitted only ahead of a non-zero coefficient.
  - Next channel → DC. After Cr, the final emitted symbol carries sym_last=1 → DONE.
- DONE: wait for the last symbol to be accepted, then go to IDLE.
- Size/amplitude:
  - size = bit length of |v| (0 for v=0).
  - amp = v for v>0; amp = (v−1) low size bits for v<0.
  - Examples: v=5 → size 3, amp 101; v=−3 → size 2, amp 00; v=−1 → size 1, amp 0.
- Saturation: |v| > 2^AMP_WIDTH−1 is clamped to ±(2^AMP_WIDTH−1) before size and amplitude are computed.
- Output register:
  - The FSM advances only when !sym_valid || sym_ready.
  - Symbol fields are stable while sym_valid && !sym_ready.
  - A zero-coefficient step advances only under the same condition; a stall freezes the scan.

## Timing
- Reset values:
  - in_ready=0 while reset is high, and 1 from the first cycle after.
  - sym_valid=0; all sym_* fields 0.
  - State IDLE; DC predictors 0.
- Latency: handshake on edge t → Y DC symbol has sym_valid=1 after edge t+1.
- Throughput without stall: one cycle per coefficient plus one per ZRL and per EOB. An all-zero block takes 3×(1+63+1) symbol/scan cycles.
- in_ready is low from capture until the sym_last symbol is accepted. in_ready=1 the cycle after that acceptance.
- Reset asserted mid-block: aborts the scan on that edge, discards the captured block, drops sym_valid, and clears predictors.

## Configuration
- JPEG_RLE_DC_PRED_EN defined:
  - The DC value is coef[0] minus the previous block's coef[0] of the same channel.
  - The predictors hold raw, unsaturated DC values.
  - Predictors update when the channel's DC symbol is accepted, and reset to 0.
- JPEG_RLE_DC_PRED_EN undefined: the DC value is the raw coef[0]; no predictor registers exist.

## Test plan
- All-zero block, sym_ready=1 → per channel: DC(size 0), EOB; 6 symbols total. Only the final Cr EOB has sym_last=1. in_ready returns high.
- Y coefs k0=12, k1=−3, k5=1, rest 0 → Y symbols: DC size 4 amp 1100; (0,2,00); (3,1,1); EOB.
- Y k20=7, rest 0 → (0..) DC, ZRL (15,0), then (3,3,111), EOB. Same input with k63=7 → DC, ZRL×3, (14,3,111), no EOB.
- Coefficient 100000 and −100000 → size 11, amp 11111111111 and 00000000000 respectively.
- Two blocks with Y DC 50 then 40, with JPEG_RLE_DC_PRED_EN → second DC: size 4, amp 0101 (−10). Without the macro → size 6, amp 101000.
- Random sym_ready backpressure, plus reset pulsed at symbol 20 → fields hold while stalled; after reset sym_valid=0 and a fresh block encodes from Y DC with predictor 0.

Source files
------------

// File: rtl/jpeg_zigzag_rle_encoder.sv
// Zigzag-ordered 8x8 block to JPEG run-length symbol stream (DC, AC run/size/amp, ZRL, EOB) for Y, Cb, Cr.
// Optional DC prediction (difference against previous block's DC per channel) with `define JPEG_RLE_DC_PRED_EN.
module jpeg_zigzag_rle_encoder #(
    parameter int DATA_WIDTH  = 32,
    parameter int PIXEL_COUNT = 64,
    parameter int AMP_WIDTH   = 11
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] zigzag_y,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] zigzag_cb,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] zigzag_cr,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              sym_valid,
    input  logic                              sym_ready,
    output logic [1:0]                        sym_channel,
    output logic                              sym_is_dc,
    output logic [3:0]                        sym_run,
    output logic [3:0]                        sym_size,
    output logic [AMP_WIDTH-1:0]              sym_amp,
    output logic                              sym_last
);
    localparam int KW = $clog2(PIXEL_COUNT) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(PIXEL_COUNT - 1);
    localparam logic [KW-1:0] K_END  = KW'(PIXEL_COUNT);
    localparam logic [DATA_WIDTH:0] SAT = (DATA_WIDTH+1)'((1 << AMP_WIDTH) - 1);

    typedef enum logic [2:0] {S_IDLE, S_DC, S_AC, S_ZRL, S_DONE} state_t;

    state_t state_q, state_d;
    logic [DATA_WIDTH*PIXEL_COUNT-1:0] y_q, cb_q, cr_q, cur_vec;
    logic [1:0]           ch_q, ch_d;
    logic [KW-1:0]        k_q, k_d, run_q, run_d;
    logic                 sym_valid_q, sym_valid_d, sym_is_dc_q, sym_is_dc_d, sym_last_q, sym_last_d;
    logic [1:0]           sym_channel_q, sym_channel_d;
    logic [3:0]           sym_run_q, sym_run_d, sym_size_q, sym_size_d;
    logic [AMP_WIDTH-1:0] sym_amp_q, sym_amp_d;

    logic                       capture, adv, emit, e_dc, e_last;
    logic [3:0]                 e_run;
    logic [AMP_WIDTH+3:0]       e_sa;
    logic [DATA_WIDTH-1:0]      coef, dc_raw;
    logic signed [DATA_WIDTH:0] coef_ext, dc_val;

    // Saturate to +-(2^AMP_WIDTH-1), then {size, amplitude}; negative amp is ~|v| masked to size bits.
    function automatic logic [AMP_WIDTH+3:0] size_amp(input logic signed [DATA_WIDTH:0] v);
        logic [DATA_WIDTH:0]  mag_full;
        logic [AMP_WIDTH-1:0] mag, amp;
        logic [3:0]           sz;
        mag_full = v[DATA_WIDTH] ? $unsigned(-v) : $unsigned(v);
        mag = (mag_full > SAT) ? '1 : mag_full[AMP_WIDTH-1:0];
        sz = '0;
        for (int unsigned i = 0; i < AMP_WIDTH; i++)
            if (mag[i]) sz = 4'(i + 1);
        amp = v[DATA_WIDTH] ? ~mag : mag;
        for (int unsigned i = 0; i < AMP_WIDTH; i++)
            if (i >= 32'(sz)) amp[i] = 1'b0;
        return {sz, amp};
    endfunction

    assign in_ready    = (state_q == S_IDLE) && !reset;
    assign sym_valid   = sym_valid_q;
    assign sym_channel = sym_channel_q;
    assign sym_is_dc   = sym_is_dc_q;
    assign sym_run     = sym_run_q;
    assign sym_size    = sym_size_q;
    assign sym_amp     = sym_amp_q;
    assign sym_last    = sym_last_q;

    always_comb begin
        case (ch_q)
            2'd0:    cur_vec = y_q;
            2'd1:    cur_vec = cb_q;
            default: cur_vec = cr_q;
        endcase
    end

    assign coef     = cur_vec[32'(k_q[KW-2:0]) * DATA_WIDTH +: DATA_WIDTH];
    assign dc_raw   = cur_vec[DATA_WIDTH-1:0];
    assign coef_ext = {coef[DATA_WIDTH-1], coef};

`ifdef JPEG_RLE_DC_PRED_EN
    logic [DATA_WIDTH-1:0] pred_y_q, pred_cb_q, pred_cr_q, pred_cur;

    always_comb begin
        case (ch_q)
            2'd0:    pred_cur = pred_y_q;
            2'd1:    pred_cur = pred_cb_q;
            default: pred_cur = pred_cr_q;
        endcase
    end

    assign dc_val = {dc_raw[DATA_WIDTH-1], dc_raw} - {pred_cur[DATA_WIDTH-1], pred_cur};

    // Predictors take the raw DC of the channel whose DC symbol is being accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_y_q  <= '0;
            pred_cb_q <= '0;
            pred_cr_q <= '0;
        end else if (sym_valid_q && sym_ready && sym_is_dc_q) begin
            case (sym_channel_q)
                2'd0:    pred_y_q  <= y_q[DATA_WIDTH-1:0];
                2'd1:    pred_cb_q <= cb_q[DATA_WIDTH-1:0];
                default: pred_cr_q <= cr_q[DATA_WIDTH-1:0];
            endcase
        end
    end
`else
    assign dc_val = {dc_raw[DATA_WIDTH-1], dc_raw};
`endif

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        k_d           = k_q;
        run_d         = run_q;
        sym_valid_d   = sym_valid_q;
        sym_channel_d = sym_channel_q;
        sym_is_dc_d   = sym_is_dc_q;
        sym_run_d     = sym_run_q;
        sym_size_d    = sym_size_q;
        sym_amp_d     = sym_amp_q;
        sym_last_d    = sym_last_q;
        capture       = 1'b0;
        emit          = 1'b0;
        e_dc          = 1'b0;
        e_last        = 1'b0;
        e_run         = '0;
        e_sa          = '0;
        adv           = !sym_valid_q || sym_ready;

        if (adv) begin
            sym_valid_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        capture = 1'b1;
                        ch_d    = '0;
                        state_d = S_DC;
                    end
                end
                S_DC: begin
                    emit    = 1'b1;
                    e_dc    = 1'b1;
                    e_sa    = size_amp(dc_val);
                    k_d     = KW'(1);
                    run_d   = '0;
                    state_d = S_AC;
                end
                S_AC, S_ZRL: begin
                    if (k_q == K_END) begin
                        emit = 1'b1;
                    end else if (coef == '0) begin
                        run_d   = run_q + 1'b1;
                        k_d     = k_q + 1'b1;
                        state_d = S_AC;
                    end else if (run_q >= KW'(16)) begin
                        emit    = 1'b1;
                        e_run   = 4'd15;
                        run_d   = run_q - KW'(16);
                        state_d = S_ZRL;
                    end else begin
                        emit    = 1'b1;
                        e_run   = run_q[3:0];
                        e_sa    = size_amp(coef_ext);
                        run_d   = '0;
                        k_d     = k_q + 1'b1;
                        state_d = S_AC;
                    end
                    // k == K_END only follows a zero at the last index, so it is the EOB slot.
                    if ((k_q == K_END) || (emit && e_run != 4'd15 && k_q == K_LAST) ||
                        (emit && run_q < KW'(16) && k_q == K_LAST)) begin
                        if (ch_q == 2'd2) begin
                            e_last  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            ch_d    = ch_q + 1'b1;
                            state_d = S_DC;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        if (emit) begin
            sym_valid_d   = 1'b1;
            sym_channel_d = ch_q;
            sym_is_dc_d   = e_dc;
            sym_run_d     = e_run;
            {sym_size_d, sym_amp_d} = e_sa;
            sym_last_d    = e_last;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            y_q  <= zigzag_y;
            cb_q <= zigzag_cb;
            cr_q <= zigzag_cr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            k_q           <= '0;
            run_q         <= '0;
            sym_valid_q   <= 1'b0;
            sym_channel_q <= '0;
            sym_is_dc_q   <= 1'b0;
            sym_run_q     <= '0;
            sym_size_q    <= '0;
            sym_amp_q     <= '0;
            sym_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            k_q           <= k_d;
            run_q         <= run_d;
            sym_valid_q   <= sym_valid_d;
            sym_channel_q <= sym_channel_d;
            sym_is_dc_q   <= sym_is_dc_d;
            sym_run_q     <= sym_run_d;
            sym_size_q    <= sym_size_d;
            sym_amp_q     <= sym_amp_d;
            sym_last_q    <= sym_last_d;
        end
    end
endmodule

// File: tb/tb_jpeg_zigzag_rle_encoder.sv
// Scoreboard bench for jpeg_zigzag_rle_encoder: stimulus pushes expected symbols, a monitor pops on acceptance.
// Expectations follow `define JPEG_RLE_DC_PRED_EN when it is set for the build.
module tb_jpeg_zigzag_rle_encoder;
    typedef struct packed {
        logic [1:0]  ch;
        logic        dc;
        logic [3:0]  run;
        logic [3:0]  size;
        logic [10:0] amp;
        logic        last;
    } sym_t;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, sym_valid, sym_ready;
    logic [2047:0] zy, zcb, zcr;
    logic [1:0]    sym_channel;
    logic          sym_is_dc, sym_last;
    logic [3:0]    sym_run, sym_size;
    logic [10:0]   sym_amp;

    sym_t    q[$];
    int      errors = 0;
    int      checks = 0;
    int      accepted = 0;
    bit      mon_en = 1'b0;
    bit      rand_ready = 1'b0;
    longint  pred_m[3];

    always #5 clk = ~clk;

    jpeg_zigzag_rle_encoder #(.DATA_WIDTH(32), .PIXEL_COUNT(64), .AMP_WIDTH(11)) dut (
        .clk(clk), .reset(reset),
        .zigzag_y(zy), .zigzag_cb(zcb), .zigzag_cr(zcr),
        .in_valid(in_valid), .in_ready(in_ready),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_channel(sym_channel), .sym_is_dc(sym_is_dc), .sym_run(sym_run),
        .sym_size(sym_size), .sym_amp(sym_amp), .sym_last(sym_last)
    );

    function automatic logic [14:0] enc_m(input longint v);
        longint s, m, a;
        if (v > 2047) v = 2047;
        if (v < -2047) v = -2047;
        m = (v < 0) ? -v : v;
        s = 0;
        while (m > 0) begin
            s++;
            m = m >> 1;
        end
        a = (v >= 0) ? v : v + (longint'(1) << s) - 1;
        return {4'(s), 11'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input int ch, input bit dc, input int run, input int size, input int amp, input bit last);
        sym_t s;
        s.ch = 2'(ch); s.dc = dc; s.run = 4'(run); s.size = 4'(size); s.amp = 11'(amp); s.last = last;
        q.push_back(s);
    endtask

    task automatic push_dc(input int ch, input longint val);
        longint d;
        logic [14:0] sa;
`ifdef JPEG_RLE_DC_PRED_EN
        d = val - pred_m[ch];
        pred_m[ch] = val;
`else
        d = val;
`endif
        sa = enc_m(d);
        push(ch, 1'b1, 0, int'(sa[14:11]), int'(sa[10:0]), 1'b0);
    endtask

    function automatic int getc(input int ch, input int k);
        logic [31:0] t;
        case (ch)
            0:       t = zy[k*32 +: 32];
            1:       t = zcb[k*32 +: 32];
            default: t = zcr[k*32 +: 32];
        endcase
        return $signed(t);
    endfunction

    task automatic set_c(input int ch, input int k, input int val);
        case (ch)
            0:       zy[k*32 +: 32] = val;
            1:       zcb[k*32 +: 32] = val;
            default: zcr[k*32 +: 32] = val;
        endcase
    endtask

    task automatic clear_vecs();
        zy = '0; zcb = '0; zcr = '0;
    endtask

    task automatic model_block();
        int run, c;
        logic [14:0] sa;
        for (int ch = 0; ch < 3; ch++) begin
            push_dc(ch, longint'(getc(ch, 0)));
            run = 0;
            for (int k = 1; k < 64; k++) begin
                c = getc(ch, k);
                if (c == 0) run++;
                else begin
                    while (run >= 16) begin
                        push(ch, 1'b0, 15, 0, 0, 1'b0);
                        run -= 16;
                    end
                    sa = enc_m(longint'(c));
                    push(ch, 1'b0, run, int'(sa[14:11]), int'(sa[10:0]), 1'b0);
                    run = 0;
                end
            end
            if (getc(ch, 63) == 0) push(ch, 1'b0, 0, 0, 0, 1'b0);
        end
        q[q.size()-1].last = 1'b1;
    endtask

    task automatic send_block();
        int i;
        for (i = 0; i < 200 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL in_ready_wait: got 0 expected 1");
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 3000 && !(q.size() == 0 && in_ready); i++) begin
            @(posedge clk); #1;
        end
        chk({name, "_done_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({name, "_queue_left"}, q.size(), 32'd0);
    endtask

    initial begin
        sym_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            sym_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        sym_t got, exp, held;
        bit stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stalled = 1'b0;
                continue;
            end
            got = {sym_channel, sym_is_dc, sym_run, sym_size, sym_amp, sym_last};
            if (sym_valid) begin
                if (stalled) begin
                    checks++;
                    if (got !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got %h expected %h", got, held);
                    end
                end
                if (sym_ready) begin
                    accepted++;
                    checks++;
                    stalled = 1'b0;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_symbol: got %h expected none", got);
                    end else begin
                        exp = q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL symbol %0d: got ch=%0d dc=%0b run=%0d size=%0d amp=%b last=%0b expected ch=%0d dc=%0b run=%0d size=%0d amp=%b last=%0b",
                                     accepted, got.ch, got.dc, got.run, got.size, got.amp, got.last,
                                     exp.ch, exp.dc, exp.run, exp.size, exp.amp, exp.last);
                        end
                    end
                end else begin
                    held = got;
                    stalled = 1'b1;
                end
            end else if (stalled) begin
                checks++;
                errors++;
                stalled = 1'b0;
                $display("FAIL stall_valid_dropped: got 0 expected 1");
            end
        end
    end

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; clear_vecs();
        pred_m = '{0, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_fields", {12'd0, sym_channel, sym_is_dc, sym_run, sym_size, sym_amp, sym_last}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // all-zero block
        clear_vecs();
        for (int ch = 0; ch < 3; ch++) begin
            push_dc(ch, 0);
            push(ch, 1'b0, 0, 0, 0, ch == 2);
        end
        send_block();
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        wait_done("allzero");

        // Y: 12, -3, 0,0,0, 1
        clear_vecs();
        set_c(0, 0, 12); set_c(0, 1, -3); set_c(0, 5, 1);
        push(0, 1'b1, 0, 4, 12, 1'b0); pred_m[0] = 12;
        push(0, 1'b0, 0, 2, 0, 1'b0);
        push(0, 1'b0, 3, 1, 1, 1'b0);
        push(0, 1'b0, 0, 0, 0, 1'b0);
        push_dc(1, 0); push(1, 1'b0, 0, 0, 0, 1'b0);
        push_dc(2, 0); push(2, 1'b0, 0, 0, 0, 1'b1);
        send_block();
        wait_done("basic");

        // Y k20=7: one ZRL then (3,3,111)
        clear_vecs();
        set_c(0, 20, 7);
        push_dc(0, 0);
        push(0, 1'b0, 15, 0, 0, 1'b0);
        push(0, 1'b0, 3, 3, 7, 1'b0);
        push(0, 1'b0, 0, 0, 0, 1'b0);
        push_dc(1, 0); push(1, 1'b0, 0, 0, 0, 1'b0);
        push_dc(2, 0); push(2, 1'b0, 0, 0, 0, 1'b1);
        send_block();
        wait_done("zrl1");

        // k63 non-zero: three ZRLs, no EOB; Cr ends on a coefficient symbol
        clear_vecs();
        set_c(0, 63, 7); set_c(2, 63, -1);
        push_dc(0, 0);
        repeat (3) push(0, 1'b0, 15, 0, 0, 1'b0);
        push(0, 1'b0, 14, 3, 7, 1'b0);
        push_dc(1, 0); push(1, 1'b0, 0, 0, 0, 1'b0);
        push_dc(2, 0);
        repeat (3) push(2, 1'b0, 15, 0, 0, 1'b0);
        push(2, 1'b0, 14, 1, 0, 1'b1);
        send_block();
        wait_done("zrl3");

        // saturation, Y DC 50
        clear_vecs();
        set_c(0, 0, 50); set_c(1, 1, 100000); set_c(1, 2, -100000); set_c(2, 0, -100000);
        push_dc(0, 50); push(0, 1'b0, 0, 0, 0, 1'b0);
        push_dc(1, 0);
        push(1, 1'b0, 0, 11, 11'h7FF, 1'b0);
        push(1, 1'b0, 0, 11, 0, 1'b0);
        push(1, 1'b0, 0, 0, 0, 1'b0);
        push_dc(2, -100000); push(2, 1'b0, 0, 0, 0, 1'b1);
        send_block();
        wait_done("sat");

        // Y DC 40 after 50
        clear_vecs();
        set_c(0, 0, 40);
`ifdef JPEG_RLE_DC_PRED_EN
        push(0, 1'b1, 0, 4, 5, 1'b0); pred_m[0] = 40;
`else
        push(0, 1'b1, 0, 6, 40, 1'b0);
`endif
        push(0, 1'b0, 0, 0, 0, 1'b0);
        push_dc(1, 0); push(1, 1'b0, 0, 0, 0, 1'b0);
        push_dc(2, 0); push(2, 1'b0, 0, 0, 0, 1'b1);
        send_block();
        wait_done("dcpred");

        // backpressure plus reset after 20 accepted symbols
        rand_ready = 1'b1;
        clear_vecs();
        set_c(0, 0, 9);
        for (int k = 1; k <= 30; k++)
            if (k % 3 != 0) set_c(0, k, (k % 2 == 1) ? k : -k);
        set_c(1, 0, -6); set_c(1, 40, 3); set_c(2, 0, 5);
        model_block();
        base = accepted;
        send_block();
        for (int i = 0; i < 2000 && accepted < base + 20; i++) begin
            @(posedge clk); #1;
        end
        chk("reached_sym20", {31'd0, accepted >= base + 20}, 32'd1);
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_sym_valid", {31'd0, sym_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        q.delete();
        pred_m = '{0, 0, 0};
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
        model_block();
        send_block();
        wait_done("after_reset");
        rand_ready = 1'b0;

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
